// File: rtl/test_srrc_designer.sv
// Square-root raised-cosine FIR (beta 0.25, 4 sps, span 8) over IEEE-754 doubles.
// Behavioral real-arithmetic model: input reg, delay line, multipliers, pairwise adder tree, pad, output reg.
module test_srrc_designer #(
  parameter int  NTAPS   = 33,
  parameter real COEFF [NTAPS] = '{
     0.010613,  0.004965, -0.009150, -0.021351, -0.018760,  0.003012,
     0.032655,  0.047062,  0.026532, -0.027503, -0.085167, -0.099380,
    -0.032125,  0.118957,  0.310966,  0.471684,  0.534270,  0.471684,
     0.310966,  0.118957, -0.032125, -0.099380, -0.085167, -0.027503,
     0.026532,  0.047062,  0.032655,  0.003012, -0.018760, -0.021351,
    -0.009150,  0.004965,  0.010613},
  parameter int  LATENCY = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [63:0] filter_in,
  output logic [63:0] filter_out
);

  localparam int TREE_LVLS = $clog2(NTAPS);
  // Stages outside the tree: input reg, delay head, products, output reg; the rest is padding.
  localparam int PAD       = LATENCY - 4 - TREE_LVLS;
  localparam int HALF      = (NTAPS + 1) / 2;

  real in_p0;
  real dly_p1  [NTAPS];
  real prod_p2 [NTAPS+1];
  real sum_p3  [TREE_LVLS][NTAPS+1];
  real pad_p9  [PAD];

  // Number of live entries produced by tree level lvl-1 (level 0 = products).
  function automatic int lvl_w(input int lvl);
    int w;
    w = NTAPS;
    for (int k = 0; k < lvl; k++) w = (w + 1) / 2;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      in_p0 <= 0.0;
      for (int i = 0; i < NTAPS; i++) dly_p1[i] <= 0.0;
      for (int i = 0; i <= NTAPS; i++) prod_p2[i] <= 0.0;
      for (int l = 0; l < TREE_LVLS; l++)
        for (int j = 0; j <= NTAPS; j++) sum_p3[l][j] <= 0.0;
      for (int k = 0; k < PAD; k++) pad_p9[k] <= 0.0;
      filter_out <= 64'h0;
    end else if (clk_enable) begin
      // p0: capture the incoming sample
      in_p0 <= $bitstoreal(filter_in);

      // p1: delay line, entry i holds x[n-i]
      dly_p1[0] <= in_p0;
      for (int i = 1; i < NTAPS; i++) dly_p1[i] <= dly_p1[i-1];

      // p2: tap products
      for (int i = 0; i < NTAPS; i++) prod_p2[i] <= COEFF[i] * dly_p1[i];

      // p3..: pairwise tree, left to right; an odd last entry passes through unchanged
      for (int j = 0; j < HALF; j++)
        sum_p3[0][j] <= (2*j + 1 < NTAPS) ? prod_p2[2*j] + prod_p2[2*j+1] : prod_p2[2*j];
      for (int l = 1; l < TREE_LVLS; l++)
        for (int j = 0; j < HALF; j++)
          sum_p3[l][j] <= (2*j + 1 < lvl_w(l)) ? sum_p3[l-1][2*j] + sum_p3[l-1][2*j+1]
                                               : sum_p3[l-1][2*j];

      // p9: latency padding, then the output register
      pad_p9[0] <= sum_p3[TREE_LVLS-1][0];
      for (int k = 1; k < PAD; k++) pad_p9[k] <= pad_p9[k-1];
      filter_out <= $realtobits(pad_p9[PAD-1]);
    end
  end

endmodule

// File: tb/tb_test_srrc_designer.sv
// Directed bench for test_srrc_designer: reset, zero input, impulse, gated impulse, step, mid-stream reset, long random.
module tb_test_srrc_designer;

  localparam int LAT  = 11;
  localparam int NT   = 33;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic [63:0] filter_in = 64'h0;
  logic [63:0] filter_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          nsamp   = 0;
  logic [63:0] exp_q   = 64'h0;
  real         hist [HMAX];

  // SRRC beta 0.25, 4 samples/symbol, span 8 symbols, unit energy
  real c [NT] = '{
     0.010613,  0.004965, -0.009150, -0.021351, -0.018760,  0.003012,
     0.032655,  0.047062,  0.026532, -0.027503, -0.085167, -0.099380,
    -0.032125,  0.118957,  0.310966,  0.471684,  0.534270,  0.471684,
     0.310966,  0.118957, -0.032125, -0.099380, -0.085167, -0.027503,
     0.026532,  0.047062,  0.032655,  0.003012, -0.018760, -0.021351,
    -0.009150,  0.004965,  0.010613};

  test_srrc_designer dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .filter_in  (filter_in),
    .filter_out (filter_out)
  );

  always #5 clk = ~clk;

  function automatic real ref_y(input int n);
    real acc;
    acc = 0.0;
    for (int i = 0; i < NT; i++)
      if (n - i >= 0) acc += c[i] * hist[n-i];
    return acc;
  endfunction

  function automatic real rnd();
    return real'($urandom_range(2000000)) / 1.0e6 - 1.0;
  endfunction

  // An expected exact zero must match bit for bit; anything else within 1e-9.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    real d;
    bit  bad;
    n_tests++;
    if (exp == 64'h0) bad = (got !== 64'h0);
    else begin
      d = $bitstoreal(got) - $bitstoreal(exp);
      if (d < 0.0) d = -d;
      bad = !(d <= 1.0e-9);
    end
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %h (%g) expected %h (%g)", tag, got, $bitstoreal(got),
               exp, $bitstoreal(exp));
    end
  endtask

  task automatic step(input logic r, input logic en, input real x, input string tag);
    reset = r;
    clk_enable = en;
    filter_in = $realtobits(x);
    @(posedge clk);
    #1;
    if (r) begin
      nsamp = 0;
      exp_q = 64'h0;
    end else if (en && nsamp < HMAX) begin
      hist[nsamp] = x;
      nsamp++;
      exp_q = (nsamp >= LAT) ? $realtobits(ref_y(nsamp - LAT)) : 64'h0;
    end
    chk(tag, filter_out, exp_q);
  endtask

  initial begin
    real sumc;

    // reset applied with enable low, then high
    step(1'b1, 1'b0, 3.5, "reset_en0");
    step(1'b1, 1'b1, 2.0, "reset_en1");
    step(1'b1, 1'b1, 0.0, "reset_state");

    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 0.0, "zero_in");

    step(1'b1, 1'b1, 0.0, "reset_imp");
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, (i == 0) ? 1.0 : 0.0, "impulse");

    // disabled cycles carry junk on filter_in that must be ignored
    step(1'b1, 1'b1, 0.0, "reset_gate");
    for (int i = 0; i < 100; i++)
      if (i % 2 == 1) step(1'b0, 1'b0, 5.0, "gate_hold");
      else step(1'b0, 1'b1, (i == 0) ? 1.0 : 0.0, "gate_imp");

    step(1'b1, 1'b1, 0.0, "reset_step");
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1.0, "step");
    sumc = 0.0;
    for (int i = 0; i < NT; i++) sumc += c[i];
    chk("step_settle", filter_out, $realtobits(sumc));

    step(1'b1, 1'b1, 0.0, "reset_mid0");
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, rnd(), "mid_pre");
    step(1'b1, 1'b0, rnd(), "mid_reset");
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, rnd(), "mid_post");

    step(1'b1, 1'b1, 0.0, "reset_long");
    for (int i = 0; i < 3779; i++) step(1'b0, 1'b1, rnd(), "long_rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
